// File: rtl/seq_prefix_adder.sv
// Multi-cycle adder/subtractor: one 4-bit slice per clock, carries within a
// slice formed by a group generate/propagate prefix, ready/valid on both sides.
module seq_prefix_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = $clog2(NSLICE + 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("seq_prefix_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [3:0]       sa, sb, sp, sg, s_sum;
  logic [4:0]       sc;

  // Current slice operands and its prefix carries; sc[0] is the carry register.
  always_comb begin
    sa    = a_q[{cnt_q, 2'b00} +: 4];
    sb    = b_q[{cnt_q, 2'b00} +: 4];
    sp    = sa | sb;
    sg    = sa & sb;
    sc[0] = carry_q;
    sc[1] = sg[0] | (sp[0] & carry_q);
    sc[2] = sg[1] | (sp[1] & sg[0]) | (&sp[1:0] & carry_q);
    sc[3] = sg[2] | (sp[2] & sg[1]) | (&sp[2:1] & sg[0]) | (&sp[2:0] & carry_q);
    sc[4] = sg[3] | (sp[3] & sg[2]) | (&sp[3:2] & sg[1]) | (&sp[3:1] & sg[0])
          | (&sp[3:0] & carry_q);
    s_sum = sa ^ sb ^ sc[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | c_in;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[{cnt_q, 2'b00} +: 4] = s_sum;
        carry_d = sc[4];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NSLICE - 1)) begin
          // Last slice: sc[3] is the carry into the MSB of the whole word.
          c_out_d = sc[4];
          ovf_d   = sc[3] ^ sc[4];
          zero_d  = (sum_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign sum         = sum_q;
  assign c_out       = c_out_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;

endmodule

// File: doc/seq_prefix_adder.md
SEQ_PREFIX_ADDER -- requirements
Module: seq_prefix_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 in 4..64, otherwise elaboration SHALL fail.
REQ-002 Derived constant NSLICE = WIDTH/4, the number of 4-bit slices processed per operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start_valid  input  1  operand request valid.
REQ-006 start_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry-in; used for add only.
REQ-010 sub  input  1  0 = A+B+c_in, 1 = A-B.
REQ-011 res_valid  output  1  result valid.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  carry out of MSB; in subtract, 1 means no borrow.
REQ-015 ovf  output  1  signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 FSM states SHALL be IDLE, CALC and DONE. start_ready SHALL be 1 only in IDLE, and res_valid SHALL be 1 only in DONE.
REQ-018 An operation SHALL be accepted on an edge where start_valid=1 and start_ready=1. On acceptance the block SHALL:
- register a;
- register b, inverted when sub=1;
- load the carry register with sub ? 1 : c_in;
- clear the slice counter to 0;
- enter CALC.
REQ-019 The a, b, c_in and sub inputs SHALL be sampled only at acceptance; changes during CALC or DONE SHALL have no effect.
REQ-020 In CALC, each edge SHALL process slice k = counter, LSB slice first. Per slice:
- P = A|B and G = A&B per bit;
- carries by 4-bit prefix (group generate/propagate) from the carry register;
- sum slice = A^B^carries, written to sum[4k+3:4k];
- carry register updated with the slice carry-out;
- counter incremented.
REQ-021 Immediately after the edge that processes slice NSLICE-1, the state SHALL be DONE. res_valid SHALL therefore rise exactly NSLICE edges after the accepting edge (4 edges for WIDTH=16).
REQ-022 On entering DONE, the flags SHALL be set as follows:
- c_out = final carry register;
- ovf = carry into bit WIDTH-1 XOR c_out;
- zero = (sum == 0).
REQ-023 In DONE with res_ready=0, sum, c_out, ovf, zero and res_valid SHALL hold stable.
REQ-024 An edge with res_valid=1 and res_ready=1 SHALL move the state to IDLE. start_ready SHALL return 1 on the following cycle; there is no same-cycle result/operand overlap.
REQ-025 start_valid asserted outside IDLE SHALL be ignored, with no queuing.
REQ-026 The counter SHALL be ceil(log2(NSLICE+1)) bits wide and SHALL never wrap within an operation.
REQ-027 sum, c_out, ovf and zero SHALL retain the last result in IDLE until the next operation begins writing them.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force:
- state IDLE;
- start_ready=1;
- res_valid=0;
- sum=0, c_out=0, ovf=0, zero=0;
- counter=0, carry register=0.
REQ-029 Reset asserted during CALC or DONE SHALL discard the operation; no partial result SHALL be presented after release.
REQ-030 After rst_n deasserts, the first accepting edge SHALL be the first rising clk edge with start_valid=1.

Verification (WIDTH=16)
REQ-031 a=0x00FF, b=0x0001, c_in=0, sub=0 -> sum=0x0100, c_out=0, ovf=0, zero=0; res_valid rises 4 edges after acceptance.
REQ-032 a=0xFFFF, b=0x0001, c_in=0, sub=0 -> sum=0x0000, c_out=1, ovf=0, zero=1 (carry ripples through all 4 slices).
REQ-033 a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, c_out=1, ovf=1; a=0x0001, b=0x0002, sub=1 -> sum=0xFFFF, c_out=0, ovf=0.
REQ-034 a=0x7FFF, b=0x0001, c_in=0, sub=0 -> sum=0x8000, ovf=1. Hold res_ready=0 for 5 cycles while start_valid=1 with new operands: outputs stay constant, start_ready=0, and the new request is not accepted until 1 cycle after the result handshake.
REQ-035 Pulse rst_n=0 after slice 1 is processed -> res_valid=0, sum=0 and start_ready=1 asynchronously. A new operation a=0x1234, b=0x1111 after release -> sum=0x2345, c_out=0.
